// File: rtl/btn_cmd_arbiter_pkg.sv
// Shared definitions for the button command arbiter: FSM state codes and default sizing.
package btn_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_GAP   = 2'b10
  } state_e;

  localparam int DEF_NUM_BTN  = 4;
  localparam int DEF_HOLD_CYC = 8;

endpackage

// File: rtl/btn_cmd_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after `last`, wrapping modulo NUM_BTN.
module btn_cmd_arbiter_rr_pick
  import btn_cmd_arbiter_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest set bit is the final assignment.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    pos       = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      pos = IDX_W'((int'(last) + k) % NUM_BTN);
      if (req[pos]) begin
        grant_idx = pos;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Latches button pulses as pending requests and issues them one at a time, round-robin,
// on a valid/ready command port, with a settle gap after every accepted command.
module btn_cmd_arbiter
  import btn_cmd_arbiter_pkg::*;
#(
  parameter int NUM_BTN  = DEF_NUM_BTN,
  parameter int IDX_W    = 2,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_pulse,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [IDX_W-1:0]   cmd_idx,
  output logic [NUM_BTN-1:0] pending,
  output logic               busy,
  output logic               ovf
);

  state_e             state_q, state_d;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [IDX_W-1:0]   cmd_idx_q, cmd_idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic               ovf_q, ovf_d;

  logic               hs;
  logic [NUM_BTN-1:0] clr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  btn_cmd_arbiter_rr_pick #(
    .NUM_BTN (NUM_BTN),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req       (pending_q),
    .last      (last_q),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign hs  = cmd_valid_q & cmd_ready;
  assign clr = hs ? (NUM_BTN'(1) << cmd_idx_q) : '0;

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_idx_d   = cmd_idx_q;
    last_d      = last_q;
    gap_d       = gap_q;
    // A pulse landing on the bit being retired re-arms it rather than counting as a duplicate.
    pending_d   = (pending_q & ~clr) | btn_pulse;
    ovf_d       = ovf_q | (|(btn_pulse & pending_q & ~clr));
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          cmd_idx_d   = pick_idx;
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          last_d      = cmd_idx_q;
          cmd_valid_d = 1'b0;
          gap_d       = CNT_W'(HOLD_CYC - 1);
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - CNT_W'(1);
      end
      default: begin
        state_d     = S_IDLE;
        cmd_valid_d = 1'b0;
        cmd_idx_d   = '0;
        gap_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_idx_q   <= '0;
      last_q      <= IDX_W'(NUM_BTN - 1);
      gap_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_idx_q   <= cmd_idx_d;
      last_q      <= last_d;
      gap_q       <= gap_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_idx   = cmd_idx_q;
  assign pending   = pending_q;
  assign busy      = (state_q != S_IDLE);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Scoreboard bench for btn_cmd_arbiter: directed scenarios followed by random pulses/backpressure.
module tb_btn_cmd_arbiter;

  localparam int NB = 4;
  localparam int IW = 2;
  localparam int HC = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btn_pulse = '0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [IW-1:0] cmd_idx;
  logic [NB-1:0] pending;
  logic          busy;
  logic          ovf;

  btn_cmd_arbiter #(
    .NUM_BTN  (NB),
    .IDX_W    (IW),
    .HOLD_CYC (HC),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pulse (btn_pulse),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_idx   (cmd_idx),
    .pending   (pending),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: request set as an integer mask, the offered command, and a cool-down count
  // of edges before a new offer may be made.
  int m_pend, m_last, m_idx, m_wait;
  bit m_valid, m_ovf;
  bit started = 1'b0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int  old_p, clr, b, j;
    bit  found;
    if (!reset) begin
      m_pend = 0; m_ovf = 0; m_last = NB - 1; m_idx = 0; m_valid = 0; m_wait = 0;
      exp_q.delete();
    end else begin
      old_p = m_pend;
      clr   = 0;
      b     = int'(btn_pulse);
      if (m_valid) begin
        if (cmd_ready) begin
          clr = 1 << m_idx;
          m_last = m_idx;
          m_valid = 0;
          m_wait = HC;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (old_p != 0) begin
        found = 0;
        for (int k = 1; k <= NB; k++) begin
          j = (m_last + k) % NB;
          if (!found && ((old_p >> j) & 1) == 1) begin
            found = 1;
            m_idx = j;
            m_valid = 1;
            exp_q.push_back(j);
          end
        end
      end
      if ((b & old_p & ~clr) != 0) m_ovf = 1;
      m_pend = (old_p & ~clr) | b;
    end
    started = 1'b1;
  end

  // Monitor: per-cycle state checks plus a scoreboard pop on every handshake.
  always @(negedge clk) begin
    if (started) begin
      chk("cmd_valid", int'(cmd_valid), int'(m_valid));
      chk("cmd_idx",   int'(cmd_idx),   m_idx);
      chk("pending",   int'(pending),   m_pend);
      chk("ovf",       int'(ovf),       int'(m_ovf));
      chk("busy",      int'(busy),      int'(m_valid || m_wait != 0));
      if (reset && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL grant_unexpected: got idx %0d, expected no command at %0t", cmd_idx, $time);
        end else begin
          chk("grant_idx", int'(cmd_idx), exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input logic [NB-1:0] p, input logic r, input logic rst);
    @(posedge clk);
    #2;
    btn_pulse = p;
    cmd_ready = r;
    reset     = rst;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) tick('0, r, 1'b1);
  endtask

  initial begin
    logic [NB-1:0] p;
    for (int i = 0; i < 3; i++) tick('0, 1'b1, 1'b0);
    tick('0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // single request, immediate accept
    tick(4'b0100, 1'b1, 1'b1);
    idle(15, 1'b1);
    // three simultaneous requests drained in round-robin order
    tick(4'b1011, 1'b1, 1'b1);
    idle(40, 1'b1);
    // backpressure holds the offer stable
    tick(4'b0010, 1'b0, 1'b1);
    idle(10, 1'b0);
    idle(15, 1'b1);
    // duplicate pulse while pending sets ovf, one grant only
    tick(4'b0010, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1);
    tick(4'b0010, 1'b0, 1'b1);
    idle(15, 1'b1);
    // wrap after last_grant=3
    tick(4'b1000, 1'b1, 1'b1);
    idle(15, 1'b1);
    tick(4'b1001, 1'b1, 1'b1);
    idle(30, 1'b1);
    // reset while a command is being offered
    tick(4'b1000, 1'b0, 1'b1);
    idle(3, 1'b0);
    tick('0, 1'b0, 1'b0);
    tick(4'b1000, 1'b1, 1'b1);
    idle(15, 1'b1);

    // random pulses, random backpressure, rare resets
    for (int c = 0; c < 1500; c++) begin
      p = '0;
      for (int i = 0; i < NB; i++) p[i] = ($urandom_range(0, 5) == 0);
      tick(p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
    end
    idle(60, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
